// File: rtl/pc_ctrl_if.sv
// Bundle of the PC register, redirect and instruction-fetch signals around pc_ctrl.
// The master modport is the controller; the slave modport is the surrounding pipeline.
interface pc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      pc_i;
  logic             trap_req_i;
  logic [31:0]      trap_addr_i;
  logic             branch_req_i;
  logic [31:0]      branch_addr_i;
  logic             id_stall_i;
  logic             if_ack_i;
  logic             if_req_o;
  logic [31:0]      if_addr_o;
  logic             pc_hold_o;
  logic             jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic             flush_o;
  logic             misalign_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    input  pc_i, trap_req_i, trap_addr_i, branch_req_i, branch_addr_i, id_stall_i, if_ack_i,
    output if_req_o, if_addr_o, pc_hold_o, jump_flag_o, jump_addr_o, flush_o, misalign_o,
           fetch_cnt_o
  );

  modport slave (
    output pc_i, trap_req_i, trap_addr_i, branch_req_i, branch_addr_i, id_stall_i, if_ack_i,
    input  if_req_o, if_addr_o, pc_hold_o, jump_flag_o, jump_addr_o, flush_o, misalign_o,
           fetch_cnt_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// PC sequencer: holds the PC through boot, runs the fetch handshake, and turns trap/branch
// requests into a one-cycle redirect (jump + flush). Trap always outranks branch.
module pc_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input logic       clk,
  input logic       rst,
  pc_ctrl_if.master bus
);

  localparam int unsigned BootW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {StBoot, StFetch, StRedir} state_e;

  state_e           r_state, w_state_next;
  logic [BootW-1:0] r_boot_cnt, w_boot_cnt_next;
  logic             r_pend_valid, w_pend_valid_next;
  logic             r_pend_trap, w_pend_trap_next;
  logic [31:0]      r_pend_addr, w_pend_addr_next;
  logic [31:0]      r_jump_addr, w_jump_addr_next;
  logic [CNT_W-1:0] r_fetch_cnt, w_fetch_cnt_next;
  logic             w_fire;
  logic [31:0]      w_target;

  assign bus.if_addr_o   = bus.pc_i;
  assign bus.fetch_cnt_o = r_fetch_cnt;
  assign w_target        = {r_pend_addr[31:2], 2'b00};

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StBoot;
      r_boot_cnt   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_addr  <= '0;
      r_jump_addr  <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_boot_cnt   <= w_boot_cnt_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_trap  <= w_pend_trap_next;
      r_pend_addr  <= w_pend_addr_next;
      r_jump_addr  <= w_jump_addr_next;
      r_fetch_cnt  <= w_fetch_cnt_next;
    end
  end

  // Next-state, pending-redirect arbitration and output decode
  always_comb begin
    w_state_next      = r_state;
    w_boot_cnt_next   = r_boot_cnt;
    w_pend_valid_next = r_pend_valid;
    w_pend_trap_next  = r_pend_trap;
    w_pend_addr_next  = r_pend_addr;
    w_jump_addr_next  = r_jump_addr;
    w_fetch_cnt_next  = r_fetch_cnt;
    w_fire            = 1'b0;
    bus.if_req_o      = 1'b0;
    bus.pc_hold_o     = 1'b1;
    bus.jump_flag_o   = 1'b0;
    bus.jump_addr_o   = r_jump_addr;
    bus.flush_o       = 1'b0;
    bus.misalign_o    = 1'b0;

    unique case (r_state)
      StBoot: begin
        // A latched trap is never displaced by a later branch
        if (bus.trap_req_i) begin
          w_pend_valid_next = 1'b1;
          w_pend_trap_next  = 1'b1;
          w_pend_addr_next  = bus.trap_addr_i;
        end else if (bus.branch_req_i && !(r_pend_valid && r_pend_trap)) begin
          w_pend_valid_next = 1'b1;
          w_pend_trap_next  = 1'b0;
          w_pend_addr_next  = bus.branch_addr_i;
        end
        if (r_boot_cnt == BootW'(BOOT_CYCLES - 1)) begin
          w_state_next = w_pend_valid_next ? StRedir : StFetch;
        end else begin
          w_boot_cnt_next = r_boot_cnt + 1'b1;
        end
      end
      StFetch: begin
        bus.if_req_o  = !bus.id_stall_i;
        w_fire        = bus.if_req_o && bus.if_ack_i;
        bus.pc_hold_o = !w_fire;
        if (w_fire) w_fetch_cnt_next = r_fetch_cnt + 1'b1;
        // An instruction acked alongside a redirect is counted, then flushed in REDIR
        if (bus.trap_req_i) begin
          w_pend_valid_next = 1'b1;
          w_pend_trap_next  = 1'b1;
          w_pend_addr_next  = bus.trap_addr_i;
          w_state_next      = StRedir;
        end else if (bus.branch_req_i) begin
          w_pend_valid_next = 1'b1;
          w_pend_trap_next  = 1'b0;
          w_pend_addr_next  = bus.branch_addr_i;
          w_state_next      = StRedir;
        end
      end
      StRedir: begin
        bus.jump_flag_o  = 1'b1;
        bus.flush_o      = 1'b1;
        bus.jump_addr_o  = w_target;
        bus.misalign_o   = (r_pend_addr[1:0] != 2'b00);
        w_jump_addr_next = w_target;
        // Branches here come from flushed instructions; only a new trap extends REDIR
        if (bus.trap_req_i) begin
          w_pend_valid_next = 1'b1;
          w_pend_trap_next  = 1'b1;
          w_pend_addr_next  = bus.trap_addr_i;
        end else begin
          w_pend_valid_next = 1'b0;
          w_pend_trap_next  = 1'b0;
          w_state_next      = StFetch;
        end
      end
      default: begin
        w_state_next = StBoot;
      end
    endcase
  end

endmodule
